sr_flag_arbiter: RTL and testbench

- Shares one bank of SR flags between N_REQ requesters. Each requester asks to set or clear one flag.
- A round-robin arbiter serialises the requests. The block drives single-cycle S/R pulses and holds the resulting flag state.
- S and R are never asserted together on any flag, so the illegal SR condition cannot occur.
- Sits between the control units and the status-flag bank.

---
 rtl/sr_flag_arbiter_if.sv | 27 ++
 rtl/sr_flag_arbiter.sv | 155 +++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// Request/grant and flag-bank signals between the control units and the
// shared SR flag arbiter. Requesters drive req/op/idx (master side); the
// arbiter drives grants, S/R pulses, flag state and error (slave side).
interface sr_flag_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = $clog2(N_FLAGS)
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [IDX_W*N_REQ-1:0] idx;
  logic [N_REQ-1:0]       gnt;
  logic [N_FLAGS-1:0]     S;
  logic [N_FLAGS-1:0]     R;
  logic [N_FLAGS-1:0]     Q;
  logic                   err;

  modport master (
    output req, op, idx,
    input  gnt, S, R, Q, err
  );

  modport slave (
    input  req, op, idx,
    output gnt, S, R, Q, err
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter in front of a bank of SR flags. One granted op per
// two cycles: the IDLE edge picks a winner and registers its S/R/err
// pulse, the APPLY edge folds the pulse into Q and clears all pulses.
// S and R are decoded from a single op, so they can never overlap.
module sr_flag_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = $clog2(N_FLAGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_flag_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_FLAGS-1:0] s_q;
  logic [N_FLAGS-1:0] r_q;
  logic [N_FLAGS-1:0] q_q;
  logic               err_q;

  logic               any_req_s;
  logic [PTR_W-1:0]   win_s;
  logic [PTR_W-1:0]   rr_d;
  logic [1:0]         op_w_s;
  logic [IDX_W-1:0]   idx_w_s;
  logic               idx_ok_s;
  logic               set_ok_s;
  logic               clr_ok_s;
  logic               err_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [N_FLAGS-1:0] s_d;
  logic [N_FLAGS-1:0] r_d;

  // Modulo-N_REQ addition for pointer/candidate arithmetic (N_REQ need not be 2^k)
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Round-robin winner search: scan downwards so the candidate closest to rr_q wins
  always_comb begin
    any_req_s = |bus.req;
    win_s     = {PTR_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[wrap_add(rr_q, k)]) begin
        win_s = wrap_add(rr_q, k);
      end else begin
        win_s = win_s;
      end
    end
    rr_d = wrap_add(win_s, 1);
  end

  // Decode the winner's op/idx into grant, one-hot S/R pulses and error
  always_comb begin
    op_w_s   = bus.op[2*int'(win_s) +: 2];
    idx_w_s  = bus.idx[IDX_W*int'(win_s) +: IDX_W];
    idx_ok_s = ({1'b0, idx_w_s} < (IDX_W+1)'(N_FLAGS));
    set_ok_s = 1'b0;
    clr_ok_s = 1'b0;
    err_d    = 1'b0;
    case (op_w_s)
      2'b01: begin
        set_ok_s = idx_ok_s;
        err_d    = ~idx_ok_s;
      end
      2'b10: begin
        clr_ok_s = idx_ok_s;
        err_d    = ~idx_ok_s;
      end
      2'b11: begin
        err_d = 1'b1;
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      gnt_d[i] = (win_s == PTR_W'(i));
    end
    for (int f = 0; f < N_FLAGS; f++) begin
      s_d[f] = set_ok_s && (idx_w_s == IDX_W'(f));
      r_d[f] = clr_ok_s && (idx_w_s == IDX_W'(f));
    end
  end

  // Two-state control FSM with registered grant, pulses and flag bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= {PTR_W{1'b0}};
      gnt_q   <= {N_REQ{1'b0}};
      s_q     <= {N_FLAGS{1'b0}};
      r_q     <= {N_FLAGS{1'b0}};
      q_q     <= {N_FLAGS{1'b0}};
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_s) begin
            state_q <= ST_APPLY;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            err_q   <= err_d;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= {N_REQ{1'b0}};
            s_q     <= {N_FLAGS{1'b0}};
            r_q     <= {N_FLAGS{1'b0}};
            err_q   <= 1'b0;
          end
        end
        ST_APPLY: begin
          state_q <= ST_IDLE;
          q_q     <= (q_q | s_q) & ~r_q;
          gnt_q   <= {N_REQ{1'b0}};
          s_q     <= {N_FLAGS{1'b0}};
          r_q     <= {N_FLAGS{1'b0}};
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= {N_REQ{1'b0}};
          s_q     <= {N_FLAGS{1'b0}};
          r_q     <= {N_FLAGS{1'b0}};
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.S   = s_q;
  assign bus.R   = r_q;
  assign bus.Q   = q_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a behavioural model predicts the
// outputs after each edge, pushes them to a queue, and the popped entry is
// compared against the DUT. A second instance with N_FLAGS=6 covers the
// out-of-range index case.
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 8;
  localparam int IW = 3;

  logic clk;
  logic rst_n;

  sr_flag_arbiter_if #(.N_REQ(NR), .N_FLAGS(NF), .IDX_W(IW)) bus ();
  sr_flag_arbiter_if #(.N_REQ(NR), .N_FLAGS(6),  .IDX_W(3))  bus6 ();

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(NF), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(6), .IDX_W(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  typedef struct packed {
    logic [NR-1:0] g;
    logic [NF-1:0] s;
    logic [NF-1:0] r;
    logic [NF-1:0] q;
    logic          e;
  } exp_t;

  exp_t sbq[$];

  int n_vec;
  int n_miss;

  // model state
  bit            m_apply;
  int            m_rr;
  logic [NR-1:0] m_g;
  logic [NF-1:0] m_s;
  logic [NF-1:0] m_r;
  logic [NF-1:0] m_q;
  logic          m_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_apply = 1'b0;
    m_rr    = 0;
    m_g     = '0;
    m_s     = '0;
    m_r     = '0;
    m_q     = '0;
    m_e     = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] ix);
    bus.op[2*i +: 2]   = o;
    bus.idx[IW*i +: IW] = ix;
  endtask

  // One clock: predict, push, advance, pop and compare
  task automatic tick();
    exp_t e;
    int   w;
    int   c;
    logic [1:0] o;
    logic [2:0] ix;
    if (m_apply) begin
      m_q     = (m_q | m_s) & ~m_r;
      m_g     = '0;
      m_s     = '0;
      m_r     = '0;
      m_e     = 1'b0;
      m_apply = 1'b0;
    end else if (bus.req != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_rr + k) % NR;
        if (w < 0 && bus.req[c]) w = c;
      end
      o   = bus.op[2*w +: 2];
      ix  = bus.idx[IW*w +: IW];
      m_g = '0;
      m_g[w] = 1'b1;
      m_s = '0;
      m_r = '0;
      m_e = 1'b0;
      case (o)
        2'b01:   m_s[ix] = 1'b1;
        2'b10:   m_r[ix] = 1'b1;
        2'b11:   m_e = 1'b1;
        default: m_e = 1'b0;
      endcase
      m_rr    = (w + 1) % NR;
      m_apply = 1'b1;
    end
    e.g = m_g; e.s = m_s; e.r = m_r; e.q = m_q; e.e = m_e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("gnt", bus.gnt, e.g);
    chk("S",   bus.S,   e.s);
    chk("R",   bus.R,   e.r);
    chk("Q",   bus.Q,   e.q);
    chk("err", bus.err, e.e);
    chk("S&R", bus.S & bus.R, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    model_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op   = '0;
    bus.idx  = '0;
    bus6.req = '0;
    bus6.op  = '0;
    bus6.idx = '0;

    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 64'd0);
    chk("rst_Q",   bus.Q,   64'd0);
    chk("rst_err", bus.err, 64'd0);
    rst_n = 1'b1;
    repeat (10) tick();

    // single set then clear on flag 5 from requester 2
    set_req(2, 2'b01, 3'd5);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    chk("set_gnt", bus.gnt, 64'h4);
    chk("set_S",   bus.S,   64'h20);
    tick();
    chk("set_Q",   bus.Q,   64'h20);
    set_req(2, 2'b10, 3'd5);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    chk("clr_R",   bus.R,   64'h20);
    tick();
    chk("clr_Q",   bus.Q,   64'h00);

    // round-robin fairness: all request, requester i sets flag i
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 2'b01, 3'(i));
    bus.req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("rr_seq", bus.gnt, 64'(4'b0001 << (j % 4)));
      tick();
      chk("rr_gap", bus.gnt, 64'd0);
    end
    bus.req = '0;
    chk("rr_Q", bus.Q, 64'h0F);

    // same-flag conflict: requester 0 sets 3, requester 1 clears 3
    do_reset();
    set_req(0, 2'b01, 3'd3);
    set_req(1, 2'b10, 3'd3);
    bus.req = 4'b0011;
    tick();
    bus.req = 4'b0010;
    chk("cf_g0", bus.gnt, 64'h1);
    chk("cf_S",  bus.S,   64'h08);
    tick();
    tick();
    bus.req = '0;
    chk("cf_g1", bus.gnt, 64'h2);
    chk("cf_R",  bus.R,   64'h08);
    tick();
    chk("cf_Q3", bus.Q[3], 64'd0);

    // illegal opcode and no-op on the main instance
    set_req(1, 2'b11, 3'd2);
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    chk("op11_err", bus.err, 64'd1);
    tick();
    set_req(3, 2'b00, 3'd1);
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    chk("op00_gnt", bus.gnt, 64'h8);
    chk("op00_err", bus.err, 64'd0);
    tick();

    // out-of-range index on the 6-flag instance
    bus6.op[1:0]  = 2'b01;
    bus6.idx[2:0] = 3'd7;
    bus6.req      = 4'b0001;
    tick();
    bus6.req = '0;
    chk("f6_gnt", bus6.gnt, 64'h1);
    chk("f6_err", bus6.err, 64'd1);
    chk("f6_S",   bus6.S,   64'd0);
    chk("f6_R",   bus6.R,   64'd0);
    tick();
    chk("f6_Q",    bus6.Q,   64'd0);
    chk("f6_err0", bus6.err, 64'd0);
    bus6.idx[2:0] = 3'd5;
    bus6.req      = 4'b0001;
    tick();
    bus6.req = '0;
    chk("f6_S5", bus6.S, 64'h20);
    tick();
    chk("f6_Q5", bus6.Q, 64'h20);

    // reset during APPLY: fill Q, grant a clear of flag 0, then pull rst_n
    for (int f = 0; f < NF; f++) begin
      set_req(0, 2'b01, 3'(f));
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      tick();
    end
    chk("fill_Q", bus.Q, 64'hFF);
    set_req(0, 2'b10, 3'd0);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    chk("mid_R", bus.R, 64'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_R0",   bus.R,   64'd0);
    chk("mid_gnt0", bus.gnt, 64'd0);
    chk("mid_Q0",   bus.Q,   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    tick();
    set_req(0, 2'b01, 3'd2);
    set_req(3, 2'b01, 3'd4);
    bus.req = 4'b1001;
    tick();
    bus.req = '0;
    chk("post_gnt", bus.gnt, 64'h1);
    tick();
    chk("post_Q", bus.Q, 64'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
